// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default address width and Gray/binary conversions.
package fifo_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned PTR_FN_W           = 32;

  function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray codes convert correctly because the upper zeros contribute nothing.
  function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
    logic [PTR_FN_W-1:0] b;
    b[PTR_FN_W-1] = g[PTR_FN_W-1];
    for (int i = PTR_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus crossing into the clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] rq1_q;
  logic [WIDTH-1:0] rq2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= d;
      rq2_q <= rq1_q;
    end
  end

  assign q = rq2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic of an async FIFO.
// Optional level/almost-full outputs are enabled with `define FIFO_WLEVEL_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
`ifdef FIFO_WLEVEL_EN
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  almost_full,
`endif
  output logic                  overflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  if (AFULL_THRESH > (32'd1 << ADDR_WIDTH)) begin : g_thresh_chk
    $error("fifo_wptr_full: AFULL_THRESH exceeds FIFO depth");
  end

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] rq2;
  logic [PW-1:0] full_tgt;

  sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rptr_gray_async),
    .q     (rq2)
  );

  // Full when the next write pointer equals the read pointer with the top two Gray bits inverted.
  assign full_tgt = {~rq2[ADDR_WIDTH -: 2], rq2[ADDR_WIDTH-2:0]};

  always_comb begin
    wr_accept  = wr_en & ~full_q;
    wbin_d     = wbin_q + PW'(wr_accept);
    wgray_d    = PW'(bin2gray(PTR_FN_W'(wbin_d)));
    full_d     = (wgray_d == full_tgt);
    overflow_d = overflow_q | (wr_en & full_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_addr   = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray = wgray_q;
  assign full      = full_q;
  assign overflow  = overflow_q;

`ifdef FIFO_WLEVEL_EN
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] wr_level_q, wr_level_d;
  logic          almost_full_q, almost_full_d;

  // Level is measured against the synchronised read pointer, so it never under-reports.
  always_comb begin
    rbin_sync     = PW'(gray2bin(PTR_FN_W'(rq2)));
    wr_level_d    = wbin_d - rbin_sync;
    almost_full_d = (32'(wr_level_d) >= AFULL_THRESH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_level_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_level_q    <= wr_level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign wr_level    = wr_level_q;
  assign almost_full = almost_full_q;
`endif

endmodule
